// File: rtl/mat_weight_loader.sv
// Burst sequencer: streams a strided weight tile from data memory into the matrix unit, one row per cycle.
// Lane data are IEEE-754 single-precision bit patterns. `MAT_WEIGHT_LOADER_ZERO_FILL_EN pads the tile with 0.0 rows.
module mat_weight_loader #(
    parameter int WIDTH              = 16,
    parameter int DATA_MEM_ADDR_SIZE = 32,
    parameter int WIDTH_ADDR_SIZE    = $clog2(WIDTH)
) (
    input  logic                           clock,
    input  logic                           reset,
    // start is a one-cycle request honoured only in IDLE without abort; busy is high from the
    // accepting edge until the edge after the done pulse, and done pulses once per completed burst.
    input  logic                           start,
    input  logic                           abort,
    input  logic [DATA_MEM_ADDR_SIZE-1:0]  base_addr,
    input  logic [DATA_MEM_ADDR_SIZE-1:0]  stride,
    input  logic [WIDTH_ADDR_SIZE:0]       row_count,
    output logic                           busy,
    output logic                           done,
    output logic [DATA_MEM_ADDR_SIZE-1:0]  data_mem_read_addr,
    input  logic [WIDTH-1:0][31:0]         data_mem_data_out,
    output logic                           unit_set_weight,
    output logic [WIDTH_ADDR_SIZE-1:0]     unit_set_weight_row,
    output logic [WIDTH-1:0][31:0]         unit_data_in,
    output logic [1:0]                     dbg_state_o
);

    localparam int CNT_W = WIDTH_ADDR_SIZE + 1;
    localparam logic [CNT_W-1:0]           WIDTH_CNT = CNT_W'(WIDTH);
    localparam logic [WIDTH_ADDR_SIZE-1:0] LAST_IDX  = WIDTH_ADDR_SIZE'(WIDTH - 1);

`ifdef MAT_WEIGHT_LOADER_ZERO_FILL_EN
    localparam bit ZERO_FILL = 1'b1;
`else
    localparam bit ZERO_FILL = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FILL  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                           state_q, state_d;
    logic [DATA_MEM_ADDR_SIZE-1:0]    addr_q, addr_d;
    logic [DATA_MEM_ADDR_SIZE-1:0]    stride_q, stride_d;
    logic [CNT_W-1:0]                 count_q, count_d;
    logic [WIDTH_ADDR_SIZE-1:0]       idx_q, idx_d;
    logic                             busy_q, busy_d;
    logic                             done_q, done_d;
    logic                             we_q, we_d;
    logic [WIDTH_ADDR_SIZE-1:0]       row_q, row_d;
    logic [WIDTH-1:0][31:0]           data_q, data_d;
    logic [CNT_W-1:0]                 clamped_count;
    logic                             last_load_row;

    assign clamped_count = (row_count > WIDTH_CNT) ? WIDTH_CNT : row_count;
    assign last_load_row = ({1'b0, idx_q} == (count_q - CNT_W'(1)));

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        count_d  = count_q;
        idx_d    = idx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        we_d     = 1'b0;
        row_d    = row_q;
        data_d   = data_q;

        case (state_q)
            S_IDLE: begin
                // IDLE also covers the done cycle, so a back-to-back start lands on the edge busy falls.
                busy_d = 1'b0;
                if (start && !abort) begin
                    busy_d   = 1'b1;
                    addr_d   = base_addr;
                    stride_d = stride;
                    count_d  = clamped_count;
                    idx_d    = '0;
                    if (clamped_count != '0) begin
                        state_d = S_LOAD;
                    end else if (ZERO_FILL) begin
                        state_d = S_FILL;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    we_d   = 1'b1;
                    row_d  = idx_q;
                    data_d = data_mem_data_out;
                    idx_d  = idx_q + WIDTH_ADDR_SIZE'(1);
                    if (last_load_row) begin
                        // Address is left on the last row read rather than advanced past it.
                        state_d = (ZERO_FILL && (count_q < WIDTH_CNT)) ? S_FILL : S_DRAIN;
                    end else begin
                        addr_d = addr_q + stride_q;
                    end
                end
            end
            S_FILL: begin
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    we_d   = 1'b1;
                    row_d  = idx_q;
                    data_d = '0;
                    idx_d  = idx_q + WIDTH_ADDR_SIZE'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_IDLE;
                if (abort) begin
                    busy_d = 1'b0;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            stride_q <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            we_q     <= 1'b0;
            row_q    <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            we_q     <= we_d;
            row_q    <= row_d;
            data_q   <= data_d;
        end
    end

    assign busy                = busy_q;
    assign done                = done_q;
    assign data_mem_read_addr  = addr_q;
    assign unit_set_weight     = we_q;
    assign unit_set_weight_row = row_q;
    assign unit_data_in        = data_q;
    assign dbg_state_o         = state_q;

endmodule

// File: tb/tb_mat_weight_loader.sv
// Scoreboard bench for mat_weight_loader: directed bursts push expected row writes, a negedge monitor checks them.
module tb_mat_weight_loader;

`ifdef MAT_WEIGHT_LOADER_ZERO_FILL_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    localparam int ENTRY_W = 4 + 512;

    logic              clock;
    logic              reset;
    logic              start;
    logic              abort;
    logic [31:0]       base_addr;
    logic [31:0]       stride;
    logic [4:0]        row_count;
    logic              busy;
    logic              done;
    logic [31:0]       data_mem_read_addr;
    logic [15:0][31:0] data_mem_data_out;
    logic              unit_set_weight;
    logic [3:0]        unit_set_weight_row;
    logic [15:0][31:0] unit_data_in;
    logic [1:0]        dbg_state_o;

    int checks = 0;
    int errors = 0;
    logic [ENTRY_W-1:0] exp_q[$];

    mat_weight_loader dut (
        .clock               (clock),
        .reset               (reset),
        .start               (start),
        .abort               (abort),
        .base_addr           (base_addr),
        .stride              (stride),
        .row_count           (row_count),
        .busy                (busy),
        .done                (done),
        .data_mem_read_addr  (data_mem_read_addr),
        .data_mem_data_out   (data_mem_data_out),
        .unit_set_weight     (unit_set_weight),
        .unit_set_weight_row (unit_set_weight_row),
        .unit_data_in        (unit_data_in),
        .dbg_state_o         (dbg_state_o)
    );

    // Clock and watchdog
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Single-precision bits of n + 0.5 for n in 0..15.
    function automatic logic [31:0] fbits(input logic [3:0] n);
        logic [5:0] m;
        int p;
        m = {1'b0, n, 1'b1};
        p = 0;
        for (int i = 0; i < 6; i++) if (m[i]) p = i;
        return {1'b0, 8'(126 + p), 23'(32'(m) << (23 - p))};
    endfunction

    // Memory word: addr 0..15 holds exactly addr+0.5; upper address bits fold in so every address is distinct.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return fbits(a[3:0]) ^ {a[31:4], 4'b0};
    endfunction

    function automatic logic [511:0] make_row(input logic [31:0] a);
        logic [511:0] r;
        for (int l = 0; l < 16; l++) r[l*32 +: 32] = mem_word(a);
        return r;
    endfunction

    assign data_mem_data_out = {16{mem_word(data_mem_read_addr)}};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: every strobe must match the head of the expected queue.
    always @(negedge clock) begin
        if (!reset && unit_set_weight) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: row %0d with no write expected at %0t", unit_set_weight_row, $time);
            end else begin
                logic [ENTRY_W-1:0] e;
                e = exp_q.pop_front();
                if ({unit_set_weight_row, unit_data_in} !== e) begin
                    errors++;
                    $display("FAIL row_write: got row %0d lane0 0x%08h lane15 0x%08h expected row %0d lane0 0x%08h lane15 0x%08h",
                             unit_set_weight_row, unit_data_in[0], unit_data_in[15],
                             e[515:512], e[31:0], e[511:480]);
                end
            end
        end
    end

    // Driver: issue one burst, push its expected writes, then check addresses, done timing and busy.
    task automatic run_burst(input logic [31:0] b, input logic [31:0] s, input logic [4:0] cnt, input int mid_start);
        int n;
        int done_at;
        int done_seen;
        n = (cnt > 5'd16) ? 16 : int'(cnt);
        for (int r = 0; r < n; r++) exp_q.push_back({4'(r), make_row(b + s * 32'(r))});
        if (ZF) for (int r = n; r < 16; r++) exp_q.push_back({4'(r), 512'b0});
        done_at = ZF ? 17 : n + 1;

        @(posedge clock);
        #1;
        start = 1'b1; base_addr = b; stride = s; row_count = cnt;
        @(posedge clock);
        #1;
        start = 1'b0;
        done_seen = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (k == 0) chk("busy_after_start", 32'(busy), 32'd1);
            if (k < n) chk("read_addr", data_mem_read_addr, b + s * 32'(k));
            if (k == mid_start) begin start = 1'b1; base_addr = 32'd500; end
            if (k == mid_start + 1) begin start = 1'b0; base_addr = b; end
            if (done) begin done_seen = k; break; end
        end
        start = 1'b0;
        chk("done_cycle", 32'(done_seen), 32'(done_at));
        @(negedge clock);
        chk("busy_fall", 32'(busy), 32'd0);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("writes_all_seen", 32'(exp_q.size()), 32'd0);
        if (n > 0) chk("read_addr_hold", data_mem_read_addr, b + s * 32'(n - 1));
        exp_q.delete();
    endtask

    task automatic run_abort;
        int done_cnt;
        exp_q.push_back({4'd0, make_row(32'd0)});
        exp_q.push_back({4'd1, make_row(32'd1)});
        @(posedge clock);
        #1;
        start = 1'b1; base_addr = 32'd0; stride = 32'd1; row_count = 5'd16;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        abort = 1'b1;
        @(posedge clock);
        #1;
        abort = 1'b0;
        @(negedge clock);
        chk("abort_strobe_low", 32'(unit_set_weight), 32'd0);
        chk("abort_busy_low", 32'(busy), 32'd0);
        chk("abort_state_idle", 32'(dbg_state_o), 32'd0);
        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (done) done_cnt++;
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        chk("abort_rows_written", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        base_addr = '0; stride = '0; row_count = '0;
        #23;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_strobe", 32'(unit_set_weight), 32'd0);
        chk("reset_row", 32'(unit_set_weight_row), 32'd0);
        chk("reset_data", 32'(|unit_data_in), 32'd0);
        chk("reset_addr", data_mem_read_addr, 32'd0);
        chk("reset_state", 32'(dbg_state_o), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        run_burst(32'd0, 32'd1, 5'd16, -1);
        run_burst(32'd100, 32'd4, 5'd3, -1);
        run_burst(32'hFFFF_FFFC, 32'd8, 5'd2, -1);
        chk("wrap_addr_hold", data_mem_read_addr, 32'h0000_0004);
        run_burst(32'd0, 32'd1, 5'd20, 5);
        run_burst(32'd200, 32'd3, 5'd0, -1);

        run_abort();
        run_burst(32'd100, 32'd4, 5'd3, -1);

        // start and abort together in IDLE: nothing may start.
        @(posedge clock);
        #1;
        start = 1'b1; abort = 1'b1; base_addr = 32'd64;
        @(posedge clock);
        #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clock);
        chk("start_abort_busy", 32'(busy), 32'd0);
        chk("start_abort_state", 32'(dbg_state_o), 32'd0);
        repeat (3) @(negedge clock);

        // Asynchronous reset mid-burst.
        for (int r = 0; r < 16; r++) exp_q.push_back({4'(r), make_row(32'(r))});
        @(posedge clock);
        #1;
        start = 1'b1; base_addr = 32'd0; stride = 32'd1; row_count = 5'd16;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_busy", 32'(busy), 32'd0);
        chk("async_reset_strobe", 32'(unit_set_weight), 32'd0);
        chk("async_reset_row", 32'(unit_set_weight_row), 32'd0);
        chk("async_reset_data", 32'(|unit_data_in), 32'd0);
        chk("async_reset_addr", data_mem_read_addr, 32'd0);
        chk("async_reset_state", 32'(dbg_state_o), 32'd0);
        exp_q.delete();
        #3;
        reset = 1'b0;

        run_burst(32'd7, 32'd1, 5'd2, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
